// File: rtl/axi_burst_slave.sv
// Byte-wide burst memory slave with independent write (AW/W/B) and read (AR/R) FSMs
// sharing a 2^MEM_BITS x 8 array. WLAST is only checked; framing errors report SLVERR.
module axi_burst_slave #(
    parameter int MEM_BITS = 8
) (
    input  logic        clk,
    input  logic        a_rst,
    input  logic        AWVALID,
    input  logic [11:0] AWADDR,
    output logic        AWREADY,
    input  logic        WVALID,
    input  logic [7:0]  WDATA,
    input  logic        WLAST,
    output logic        WREADY,
    output logic        BVALID,
    input  logic        BREADY,
    output logic        BRESP,
    input  logic        ARVALID,
    input  logic [11:0] ARADDR,
    output logic        ARREADY,
    output logic        RVALID,
    output logic [7:0]  RDATA,
    output logic        RLAST,
    input  logic        RREADY
);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    logic [7:0] mem [2**MEM_BITS];

    logic [1:0]          w_state;
    logic [MEM_BITS-1:0] w_ptr;
    logic [4:0]          w_len;
    logic [3:0]          w_count;
    logic                w_err;
    logic                w_fire;
    logic                w_final;

    logic [0:0]          r_state;
    logic [MEM_BITS-1:0] r_ptr;
    logic [MEM_BITS-1:0] r_next;
    logic [MEM_BITS-1:0] ar_base;
    logic [4:0]          ar_len;
    logic [4:0]          r_len;
    logic [3:0]          r_count;

    // A LEN field of 0 encodes a 16-beat burst.
    function automatic logic [4:0] decode_len(input logic [3:0] field);
        return (field == 4'd0) ? 5'd16 : {1'b0, field};
    endfunction

    assign AWREADY = (w_state == W_IDLE);
    assign WREADY  = (w_state == W_DATA);
    assign BVALID  = (w_state == W_RESP);
    assign BRESP   = w_err & (w_state == W_RESP);
    assign ARREADY = (r_state == R_IDLE);
    assign RVALID  = (r_state == R_DATA);

    assign w_fire  = (w_state == W_DATA) && WVALID;
    assign w_final = ({1'b0, w_count} == (w_len - 5'd1));

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            w_state <= W_IDLE;
            w_ptr   <= '0;
            w_len   <= '0;
            w_count <= '0;
            w_err   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (AWVALID) begin
                        w_ptr   <= AWADDR[MEM_BITS+3:4];
                        w_len   <= decode_len(AWADDR[3:0]);
                        w_count <= '0;
                        w_err   <= 1'b0;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (WVALID) begin
                        w_ptr   <= w_ptr + MEM_BITS'(1);
                        w_count <= w_count + 4'd1;
                        if (WLAST != w_final) w_err <= 1'b1;
                        if (w_final) w_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (BREADY) w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Memory contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_fire) mem[w_ptr] <= WDATA;
    end

    assign ar_base = ARADDR[MEM_BITS+3:4];
    assign ar_len  = decode_len(ARADDR[3:0]);
    assign r_next  = r_ptr + MEM_BITS'(1);

    // RDATA/RLAST only change on a completed beat, so they hold through stalls.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            r_state <= R_IDLE;
            r_ptr   <= '0;
            r_len   <= '0;
            r_count <= '0;
            RDATA   <= 8'h00;
            RLAST   <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ARVALID) begin
                        r_ptr   <= ar_base;
                        r_len   <= ar_len;
                        r_count <= '0;
                        RDATA   <= mem[ar_base];
                        RLAST   <= (ar_len == 5'd1);
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        if (!RLAST) begin
                            r_ptr   <= r_next;
                            r_count <= r_count + 4'd1;
                            RDATA   <= mem[r_next];
                            RLAST   <= (({1'b0, r_count} + 5'd1) == (r_len - 5'd1));
                        end else begin
                            r_state <= R_IDLE;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule
